grid_erosion_engine: RTL and testbench

Iterative grid-erosion solver, second generation of our occupancy-grid engines. It accepts a WIDTH×DEPTH bit grid streamed in one row per handshake and repeatedly removes every occupied cell with fewer than THRESH occupied 8-neighbours. It runs either a single pass or rounds until a fixpoint, reporting total cells removed and rounds performed. The scan is row-serial (one row per cycle), so logic scales with WIDTH rather than WIDTH×DEPTH.

---
 rtl/grid_erosion_pkg.sv | 17 +
 rtl/grid_erosion_row_marker.sv | 37 +++
 rtl/grid_erosion_engine.sv | 153 +++++++++++++++
 tb/tb_grid_erosion_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_erosion_pkg.sv
// rtl/grid_erosion_pkg.sv - shared state encoding and width helpers for the grid erosion engine
package grid_erosion_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_UPDATE,
        ST_DONE
    } state_t;

    // Bits needed to hold the number of marked cells in one row.
    function automatic int pop_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/grid_erosion_row_marker.sv
// rtl/grid_erosion_row_marker.sv - marks occupied cells of one row with fewer than THRESH occupied neighbours
module grid_erosion_row_marker #(
    parameter int WIDTH  = 16,
    parameter int THRESH = 4,
    parameter int POP_W  = 5
) (
    input  logic [WIDTH-1:0] above,
    input  logic [WIDTH-1:0] current,
    input  logic [WIDTH-1:0] below,
    output logic [WIDTH-1:0] mark,
    output logic [POP_W-1:0] popcount
);

    // One zero column on each side makes the grid edges count as empty.
    logic [WIDTH+1:0] a_ext;
    logic [WIDTH+1:0] c_ext;
    logic [WIDTH+1:0] b_ext;
    int               n;

    assign a_ext = {1'b0, above, 1'b0};
    assign c_ext = {1'b0, current, 1'b0};
    assign b_ext = {1'b0, below, 1'b0};

    always_comb begin
        mark     = '0;
        popcount = '0;
        n        = 0;
        for (int c = 0; c < WIDTH; c++) begin
            n = int'(a_ext[c]) + int'(a_ext[c+1]) + int'(a_ext[c+2])
              + int'(c_ext[c]) + int'(c_ext[c+2])
              + int'(b_ext[c]) + int'(b_ext[c+1]) + int'(b_ext[c+2]);
            mark[c]  = current[c] && (n < THRESH);
            popcount = popcount + POP_W'(mark[c]);
        end
    end

endmodule

// File: rtl/grid_erosion_engine.sv
// rtl/grid_erosion_engine.sv - row-serial iterative erosion of a streamed occupancy grid
module grid_erosion_engine
    import grid_erosion_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 16,
    parameter int THRESH  = 4,
    parameter int CNT_W   = 32,
    parameter int ROUND_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic               row_valid,
    output logic               row_ready,
    input  logic [WIDTH-1:0]   row_data,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   total_removed,
    output logic [ROUND_W-1:0] rounds
);

    localparam int                POP_W    = pop_width(WIDTH);
    localparam int                ROW_W    = $clog2(DEPTH);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(DEPTH - 1);

    if (CNT_W < $clog2(WIDTH * DEPTH + 1)) begin : g_bad_cnt_w
        $error("CNT_W cannot hold WIDTH*DEPTH");
    end
    if (THRESH < 1 || THRESH > 8) begin : g_bad_thresh
        $error("THRESH must be in 1..8");
    end
    if (WIDTH < 2 || DEPTH < 2) begin : g_bad_dims
        $error("WIDTH and DEPTH must be at least 2");
    end

    state_t                       state_q;
    state_t                       state_d;
    logic                         mode_q;
    logic [ROW_W-1:0]             row_idx;
    logic [CNT_W-1:0]             round_removed;
    logic [DEPTH-1:0][WIDTH-1:0]  grid;
    logic [DEPTH-1:0][WIDTH-1:0]  mark;
    logic [WIDTH-1:0]             above_row;
    logic [WIDTH-1:0]             below_row;
    logic [WIDTH-1:0]             row_mark;
    logic [POP_W-1:0]             row_pop;
    logic                         last_row;
    logic                         round_empty;

    assign last_row    = (row_idx == LAST_ROW);
    assign round_empty = (round_removed == '0);

    always_comb begin
        above_row = '0;
        below_row = '0;
        if (row_idx != '0) above_row = grid[row_idx - ROW_W'(1)];
        if (!last_row)     below_row = grid[row_idx + ROW_W'(1)];
    end

    grid_erosion_row_marker #(
        .WIDTH  (WIDTH),
        .THRESH (THRESH),
        .POP_W  (POP_W)
    ) u_row_marker (
        .above    (above_row),
        .current  (grid[row_idx]),
        .below    (below_row),
        .mark     (row_mark),
        .popcount (row_pop)
    );

    always_comb begin
        state_d   = state_q;
        row_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_DONE: begin
                done = 1'b1;
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                row_ready = 1'b1;
                busy      = 1'b1;
                if (row_valid && last_row) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                busy = 1'b1;
                if (last_row) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                busy    = 1'b1;
                state_d = (!mode_q || round_empty) ? ST_DONE : ST_SCAN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mode_q        <= 1'b0;
            row_idx       <= '0;
            round_removed <= '0;
            total_removed <= '0;
            rounds        <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_q        <= mode;
                        row_idx       <= '0;
                        round_removed <= '0;
                        total_removed <= '0;
                        rounds        <= '0;
                    end
                end
                ST_LOAD: begin
                    if (row_valid) row_idx <= last_row ? '0 : row_idx + ROW_W'(1);
                end
                ST_SCAN: begin
                    round_removed <= round_removed + CNT_W'(row_pop);
                    row_idx       <= last_row ? '0 : row_idx + ROW_W'(1);
                end
                ST_UPDATE: begin
                    total_removed <= total_removed + round_removed;
                    if (!round_empty && rounds != '1) rounds <= rounds + ROUND_W'(1);
                    round_removed <= '0;
                    row_idx       <= '0;
                end
                default: ;
            endcase
        end
    end

    // Grid contents carry no reset; every run reloads all rows before scanning.
    always_ff @(posedge clk) begin
        case (state_q)
            ST_LOAD:   if (row_valid) grid[row_idx] <= row_data;
            ST_SCAN:   mark[row_idx] <= row_mark;
            ST_UPDATE: begin
                grid <= grid & ~mark;
                mark <= '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_grid_erosion_engine.sv
// tb/tb_grid_erosion_engine.sv - table-driven scoreboard bench for grid_erosion_engine
module tb_grid_erosion_engine;

    typedef logic [9:0][9:0] grid_t;

    typedef struct {
        int    sel;
        bit    mode;
        bit    toggle;
        grid_t g;
        int    exp_total;
        int    exp_rounds;
        int    scan_start_at;
    } tcase_t;

    typedef struct {
        int total;
        int rounds;
        int lat;
        int load_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        row_valid = 1'b0;
    logic [9:0]  row_data = '0;
    int          sel = 0;
    logic        rdy [3];
    logic        bsy [3];
    logic        dn  [3];
    logic [31:0] tot [3];
    logic [15:0] rnd [3];

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    grid_erosion_engine #(.WIDTH(10), .DEPTH(10), .THRESH(4)) dut0 (
        .clk(clk), .rst(rst), .start(start && sel == 0), .mode(mode),
        .row_valid(row_valid && sel == 0), .row_ready(rdy[0]), .row_data(row_data),
        .busy(bsy[0]), .done(dn[0]), .total_removed(tot[0]), .rounds(rnd[0]));

    grid_erosion_engine #(.WIDTH(4), .DEPTH(4), .THRESH(4)) dut1 (
        .clk(clk), .rst(rst), .start(start && sel == 1), .mode(mode),
        .row_valid(row_valid && sel == 1), .row_ready(rdy[1]), .row_data(row_data[3:0]),
        .busy(bsy[1]), .done(dn[1]), .total_removed(tot[1]), .rounds(rnd[1]));

    grid_erosion_engine #(.WIDTH(4), .DEPTH(4), .THRESH(1)) dut2 (
        .clk(clk), .rst(rst), .start(start && sel == 2), .mode(mode),
        .row_valid(row_valid && sel == 2), .row_ready(rdy[2]), .row_data(row_data[3:0]),
        .busy(bsy[2]), .done(dn[2]), .total_removed(tot[2]), .rounds(rnd[2]));

    function automatic int dim(input int s);
        return (s == 0) ? 10 : 4;
    endfunction

    function automatic int thr(input int s);
        return (s == 2) ? 1 : 4;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Whole-grid reference: recount every cell against the start-of-round grid.
    task automatic model(input grid_t g_in, input int d, input int t, input bit m,
                         output int mtot, output int mrnd);
        grid_t g;
        grid_t nx;
        int    cnt;
        int    rem;
        g    = g_in;
        mtot = 0;
        mrnd = 0;
        for (int it = 0; it < 200; it++) begin
            rem = 0;
            nx  = g;
            for (int r = 0; r < d; r++) begin
                for (int c = 0; c < d; c++) begin
                    if (g[r][c]) begin
                        cnt = 0;
                        for (int dr = -1; dr <= 1; dr++)
                            for (int dc = -1; dc <= 1; dc++)
                                if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < d &&
                                    c + dc >= 0 && c + dc < d && g[r+dr][c+dc])
                                    cnt++;
                        if (cnt < t) begin
                            nx[r][c] = 1'b0;
                            rem++;
                        end
                    end
                end
            end
            g    = nx;
            mtot += rem;
            if (rem != 0) mrnd++;
            if (!m || rem == 0) break;
        end
    endtask

    task automatic pulse_start(input int s, input bit m);
        sel   = s;
        mode  = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = ~m;
        chk("ready_after_start", rdy[s], 1);
        chk("busy_after_start", bsy[s], 1);
    endtask

    task automatic load_grid(input int s, input grid_t g, input bit toggle, output int load_cyc);
        int r     = 0;
        int guard = 0;
        bit ph    = 1'b0;
        bit rv;
        bit rd;
        load_cyc = 0;
        while (r < dim(s) && guard < 200) begin
            rv        = !toggle || !ph;
            row_valid = rv;
            row_data  = g[r];
            rd        = rdy[s];
            @(posedge clk); #1;
            if (rd) load_cyc++;
            if (rv && rd) r++;
            ph = !ph;
            guard++;
        end
        row_valid = 1'b0;
        row_data  = '0;
    endtask

    task automatic run_case(input tcase_t tc);
        exp_t e;
        int   mt;
        int   mr;
        int   lc;
        int   lat;
        int   d;
        d = dim(tc.sel);
        model(tc.g, d, thr(tc.sel), tc.mode, mt, mr);
        e.total    = (tc.exp_total  >= 0) ? tc.exp_total  : mt;
        e.rounds   = (tc.exp_rounds >= 0) ? tc.exp_rounds : mr;
        e.lat      = tc.mode ? (mr + 1) * (d + 1) : d + 1;
        e.load_cyc = tc.toggle ? 2 * d - 1 : d;
        sb.push_back(e);
        pulse_start(tc.sel, tc.mode);
        load_grid(tc.sel, tc.g, tc.toggle, lc);
        lat = 0;
        while (!dn[tc.sel] && lat < 1000) begin
            start = (lat == tc.scan_start_at);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        e = sb.pop_front();
        chk("total_removed", tot[tc.sel], e.total);
        chk("rounds", rnd[tc.sel], e.rounds);
        chk("done_latency", lat, e.lat);
        chk("load_cycles", lc, e.load_cyc);
        chk("busy_in_done", bsy[tc.sel], 0);
        repeat (2) @(posedge clk);
        #1;
        chk("done_hold", dn[tc.sel], 1);
        chk("total_hold", tot[tc.sel], e.total);
    endtask

    function automatic tcase_t mk(input int s, input bit m, input bit tg, input grid_t g,
                                  input int et, input int er, input int ssa);
        tcase_t t;
        t.sel = s; t.mode = m; t.toggle = tg; t.g = g;
        t.exp_total = et; t.exp_rounds = er; t.scan_start_at = ssa;
        return t;
    endfunction

    initial begin
        string  pz [10];
        grid_t  puzzle;
        grid_t  zeros;
        grid_t  ones4;
        grid_t  single;
        grid_t  rg;
        tcase_t cases [8];
        int     lc;

        pz = '{"..@@.@@@@.", "@@@.@.@.@@", "@@@@@.@.@@", "@.@@@@..@.", "@@.@@@@.@@",
               ".@@@@@@@.@", ".@.@.@.@@@", "@.@@@.@@@@", ".@@@@@@@@.", "@.@.@@@.@."};
        puzzle = '0;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                puzzle[r][c] = (pz[r][c] == 8'h40);
        zeros = '0;
        ones4 = '0;
        for (int r = 0; r < 4; r++) ones4[r] = 10'h00F;
        single       = '0;
        single[2][2] = 1'b1;

        cases[0] = mk(0, 1'b0, 1'b0, puzzle, 13, 1, -1);
        cases[1] = mk(0, 1'b1, 1'b0, puzzle, 43, -1, -1);
        cases[2] = mk(1, 1'b1, 1'b0, zeros, 0, 0, -1);
        cases[3] = mk(1, 1'b1, 1'b0, ones4, 4, 1, -1);
        cases[4] = mk(1, 1'b0, 1'b0, single, 1, 1, -1);
        cases[5] = mk(2, 1'b1, 1'b0, single, 1, 1, -1);
        cases[6] = mk(0, 1'b1, 1'b1, puzzle, 43, -1, -1);
        cases[7] = mk(2, 1'b1, 1'b1, ones4, 0, 0, -1);

        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("rst_row_ready", rdy[s], 0);
            chk("rst_busy", bsy[s], 0);
            chk("rst_done", dn[s], 0);
            chk("rst_total", tot[s], 0);
            chk("rst_rounds", rnd[s], 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_case(cases[i]);

        for (int i = 0; i < 6; i++) begin
            rg = '0;
            for (int r = 0; r < dim(i % 3); r++)
                rg[r] = 10'($urandom_range(0, 1023)) & ((10'h3FF) >> (10 - dim(i % 3)));
            run_case(mk(i % 3, 1'($urandom_range(0, 1)), 1'(i == 4), rg, -1, -1, -1));
        end

        // Abort a mode-1 run in its second round, then rerun from scratch.
        pulse_start(1, 1'b1);
        load_grid(1, ones4, 1'b0, lc);
        repeat (7) @(posedge clk);
        #1;
        chk("pre_rst_total", tot[1], 4);
        chk("pre_rst_busy", bsy[1], 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_row_ready", rdy[1], 0);
        chk("mid_rst_busy", bsy[1], 0);
        chk("mid_rst_done", dn[1], 0);
        chk("mid_rst_total", tot[1], 0);
        chk("mid_rst_rounds", rnd[1], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_case(mk(1, 1'b1, 1'b0, ones4, 4, 1, 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
